// File: rtl/id_imm_sched_pkg.sv
// Shared types and constants for the OTTER decode-stage immediate scheduler.
package otter_id_pkg;

   // Immediate form selected for an instruction
   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_sel_t;

   // Scheduler state: RUN issues normally, BUBBLE marks the cycle after a load-use bubble
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } sched_state_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/id_imm_sched_decode.sv
// Combinational opcode classifier: immediate form, source-register usage, load and illegal flags.
module imm_type_decode
   import otter_id_pkg::*;
(
   input  logic [6:0] opcode,
   output imm_sel_t   imm_sel,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       is_load,
   output logic       illegal
);

   // Map each opcode class to its immediate form and register reads
   always_comb begin
      imm_sel  = IMM_NONE;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      is_load  = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OP_IMM, OP_JALR, OP_SYSTEM: begin
            imm_sel  = IMM_I;
            uses_rs1 = 1'b1;
         end
         OP_LOAD: begin
            imm_sel  = IMM_I;
            uses_rs1 = 1'b1;
            is_load  = 1'b1;
         end
         OP_STORE: begin
            imm_sel  = IMM_S;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            imm_sel  = IMM_B;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         OP_JAL:           imm_sel = IMM_J;
         OP_REG: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_imm_sched.sv
// Decode-stage sequencer: selects the immediate, fills the ID/EX register,
// inserts one bubble on load-use hazards, honours flushes, counts stalls/bubbles.
//
// Handshake: a transfer happens on a rising edge where VALID and READY are both 1;
// a producer holding VALID with READY low keeps its payload stable until accepted.
module id_imm_sched
   import otter_id_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               IF_VALID,
   output logic               IF_READY,
   input  logic [31:0]        IF_IR,
   input  logic [31:0]        IF_PC,
   output logic [31:0]        IMM_IR,
   input  logic [31:0]        U_IMM,
   input  logic [31:0]        I_IMM,
   input  logic [31:0]        S_IMM,
   input  logic [31:0]        B_IMM,
   input  logic [31:0]        J_IMM,
   input  logic               FLUSH,
   output logic               EX_VALID,
   input  logic               EX_READY,
   output logic [31:0]        EX_IR,
   output logic [31:0]        EX_PC,
   output logic [31:0]        EX_IMM,
   output logic [2:0]         EX_IMM_SEL,
   output logic               EX_ILLEGAL,
   output logic [CNT_W-1:0]   STALL_CNT,
   output logic [CNT_W-1:0]   BUBBLE_CNT,
   output sched_state_t       DBG_STATE
);

   imm_sel_t          dec_sel;
   logic              dec_uses_rs1, dec_uses_rs2, dec_is_load, dec_illegal;
   logic [31:0]       imm_val;
   logic              load_en, hazard, if_ready;

   sched_state_t      state_q, state_d;
   logic              ex_valid_q, ex_valid_d;
   logic [31:0]       ex_ir_q, ex_ir_d;
   logic [31:0]       ex_pc_q, ex_pc_d;
   logic [31:0]       ex_imm_q, ex_imm_d;
   imm_sel_t          ex_sel_q, ex_sel_d;
   logic              ex_illegal_q, ex_illegal_d;
   logic              ex_is_load_q, ex_is_load_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

   imm_type_decode u_decode (
      .opcode   (IF_IR[6:0]),
      .imm_sel  (dec_sel),
      .uses_rs1 (dec_uses_rs1),
      .uses_rs2 (dec_uses_rs2),
      .is_load  (dec_is_load),
      .illegal  (dec_illegal)
   );

   assign IMM_IR = IF_IR;

   // Pick the generator output that matches the decoded immediate form
   always_comb begin
      imm_val = 32'h0;
      case (dec_sel)
         IMM_I:   imm_val = I_IMM;
         IMM_S:   imm_val = S_IMM;
         IMM_B:   imm_val = B_IMM;
         IMM_U:   imm_val = U_IMM;
         IMM_J:   imm_val = J_IMM;
         default: imm_val = 32'h0;
      endcase
   end

   // Load-use detection against the load currently held in ID/EX
   always_comb begin
      load_en  = !ex_valid_q | EX_READY;
      hazard   = ex_valid_q & ex_is_load_q & (ex_ir_q[11:7] != 5'd0) & IF_VALID &
                 ((dec_uses_rs1 & (IF_IR[19:15] == ex_ir_q[11:7])) |
                  (dec_uses_rs2 & (IF_IR[24:20] == ex_ir_q[11:7])));
      if_ready = FLUSH | (load_en & !hazard);
   end

   // Next-state for the FSM, the ID/EX register and the counters; FLUSH dominates
   always_comb begin
      state_d      = state_q;
      ex_valid_d   = ex_valid_q;
      ex_ir_d      = ex_ir_q;
      ex_pc_d      = ex_pc_q;
      ex_imm_d     = ex_imm_q;
      ex_sel_d     = ex_sel_q;
      ex_illegal_d = ex_illegal_q;
      ex_is_load_d = ex_is_load_q;
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;

      if (IF_VALID && !if_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      if (FLUSH) begin
         ex_valid_d = 1'b0;
         state_d    = ST_RUN;
      end else if (hazard && EX_READY) begin
         ex_valid_d = 1'b0;
         state_d    = ST_BUBBLE;
         if (bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else begin
         // BUBBLE always lasts exactly one cycle; the emptied register then loads normally
         state_d = ST_RUN;
         if (load_en) begin
            ex_valid_d = IF_VALID;
            if (IF_VALID) begin
               ex_ir_d      = IF_IR;
               ex_pc_d      = IF_PC;
               ex_imm_d     = imm_val;
               ex_sel_d     = dec_sel;
               ex_illegal_d = dec_illegal;
               ex_is_load_d = dec_is_load;
            end
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_RUN;
         ex_valid_q   <= 1'b0;
         ex_ir_q      <= NOP_INSTR;
         ex_pc_q      <= 32'h0;
         ex_imm_q     <= 32'h0;
         ex_sel_q     <= IMM_NONE;
         ex_illegal_q <= 1'b0;
         ex_is_load_q <= 1'b0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         ex_valid_q   <= ex_valid_d;
         ex_ir_q      <= ex_ir_d;
         ex_pc_q      <= ex_pc_d;
         ex_imm_q     <= ex_imm_d;
         ex_sel_q     <= ex_sel_d;
         ex_illegal_q <= ex_illegal_d;
         ex_is_load_q <= ex_is_load_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign IF_READY   = if_ready;
   assign EX_VALID   = ex_valid_q;
   assign EX_IR      = ex_ir_q;
   assign EX_PC      = ex_pc_q;
   assign EX_IMM     = ex_imm_q;
   assign EX_IMM_SEL = ex_sel_q;
   assign EX_ILLEGAL = ex_illegal_q;
   assign STALL_CNT  = stall_cnt_q;
   assign BUBBLE_CNT = bubble_cnt_q;
   assign DBG_STATE  = state_q;

endmodule
